// File: rtl/bcd_time_of_day.sv
// bcd_time_of_day: packed-BCD time-of-day counter with seconds prescaler,
// run-time 12/24-hour display, validated time set, carry/day-rollover pulses.
// Optional alarm comparator compiled in with `define BCD_TOD_ALARM_EN.
module bcd_time_of_day #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       mode24,
  input  logic       set_valid,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  input  logic       set_pm,
`ifdef BCD_TOD_ALARM_EN
  input  logic       alarm_wr,
  input  logic       alarm_clr,
  input  logic [7:0] al_hh,
  input  logic [7:0] al_mm,
  input  logic       al_pm,
  output logic       alarm,
`endif
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       sec_pulse,
  output logic       day_roll,
  output logic       set_err
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       h24_r, m_r, s_r;
  logic [7:0]       h_inc, m_inc, s_inc;
  logic             wrap;
  logic             set_ok, load, tick, adv;
  logic             al_err;

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [4:0] hr_bin(input logic [7:0] v);
    return 5'(v[7:4]) * 5'd10 + 5'(v[3:0]);
  endfunction

  function automatic logic [7:0] hr_bcd(input logic [4:0] b);
    if (b >= 5'd20)      return {4'd2, 4'(b - 5'd20)};
    else if (b >= 5'd10) return {4'd1, 4'(b - 5'd10)};
    else                 return {4'd0, b[3:0]};
  endfunction

  function automatic logic hr_ok(input logic [7:0] h, input logic m24);
    if (!bcd_ok(h)) return 1'b0;
    if (m24)        return h <= 8'h23;
    return (h >= 8'h01) && (h <= 8'h12);
  endfunction

  function automatic logic [7:0] hr_to24(input logic [7:0] h, input logic p,
                                        input logic m24);
    if (m24)         return h;
    if (h == 8'h12)  return p ? 8'h12 : 8'h00;
    if (p)           return hr_bcd(hr_bin(h) + 5'd12);
    return h;
  endfunction

  function automatic logic [7:0] inc60(input logic [7:0] v);
    if (v == 8'h59)        return 8'h00;
    if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Request qualification and the value time would take on a second advance
  always_comb begin
    set_ok = bcd_ok(set_mm) && (set_mm <= 8'h59) &&
             bcd_ok(set_ss) && (set_ss <= 8'h59) && hr_ok(set_hh, mode24);
    load   = set_valid && set_ok;
    tick   = ena && (div_cnt == DIV_LAST);
    adv    = tick && !load;
    s_inc  = inc60(s_r);
    m_inc  = m_r;
    h_inc  = h24_r;
    wrap   = 1'b0;
    if (s_r == 8'h59) begin
      m_inc = inc60(m_r);
      if (m_r == 8'h59) begin
        if (h24_r == 8'h23) begin
          h_inc = 8'h00;
          wrap  = 1'b1;
        end else begin
          h_inc = hr_bcd(hr_bin(h24_r) + 5'd1);
        end
      end
    end
  end

  // Time, prescaler and status pulses; a valid set overrides a same-cycle advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      h24_r     <= '0;
      m_r       <= '0;
      s_r       <= '0;
      sec_pulse <= 1'b0;
      day_roll  <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      sec_pulse <= 1'b0;
      day_roll  <= 1'b0;
      set_err   <= (set_valid && !set_ok) || al_err;
      if (load) begin
        h24_r   <= hr_to24(set_hh, set_pm, mode24);
        m_r     <= set_mm;
        s_r     <= set_ss;
        div_cnt <= '0;
      end else if (ena) begin
        if (tick) begin
          div_cnt   <= '0;
          h24_r     <= h_inc;
          m_r       <= m_inc;
          s_r       <= s_inc;
          sec_pulse <= 1'b1;
          day_roll  <= wrap;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
    end
  end

`ifdef BCD_TOD_ALARM_EN
  logic [7:0] al_h24_r, al_m_r;
  logic       armed;
  logic       al_ok;

  // Alarm write qualification; a clear in the same cycle suppresses the write
  always_comb begin
    al_ok  = bcd_ok(al_mm) && (al_mm <= 8'h59) && hr_ok(al_hh, mode24);
    al_err = alarm_wr && !alarm_clr && !al_ok;
  end

  // Alarm register, arm flag and match pulse registered with the advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      al_h24_r <= '0;
      al_m_r   <= '0;
      armed    <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      alarm <= armed && adv && (s_inc == 8'h00) &&
               (m_inc == al_m_r) && (h_inc == al_h24_r);
      if (alarm_clr) begin
        armed <= 1'b0;
      end else if (alarm_wr && al_ok) begin
        al_h24_r <= hr_to24(al_hh, al_pm, mode24);
        al_m_r   <= al_mm;
        armed    <= 1'b1;
      end
    end
  end
`else
  // Without the alarm option nothing can raise an alarm-write error
  always_comb begin
    al_err = 1'b0;
  end
`endif

  // Display decode from the 24-hour state in the selected format
  always_comb begin
    mm = m_r;
    ss = s_r;
    pm = (h24_r >= 8'h12);
    if (mode24)                hh = h24_r;
    else if (h24_r == 8'h00)   hh = 8'h12;
    else if (h24_r > 8'h12)    hh = hr_bcd(hr_bin(h24_r) - 5'd12);
    else                       hh = h24_r;
  end

endmodule

// File: tb/tb_bcd_time_of_day.sv
// Directed self-checking bench for bcd_time_of_day (TICK_DIV=4).
// Alarm steps are compiled only when BCD_TOD_ALARM_EN is defined.
module tb_bcd_time_of_day;

  logic       clk = 1'b0;
  logic       reset, ena, mode24, set_valid, set_pm;
  logic [7:0] set_hh, set_mm, set_ss;
  logic [7:0] hh, mm, ss;
  logic       pm, sec_pulse, day_roll, set_err;
`ifdef BCD_TOD_ALARM_EN
  logic       alarm_wr, alarm_clr, al_pm, alarm;
  logic [7:0] al_hh, al_mm;
`endif

  int unsigned checks = 0;
  int unsigned failures = 0;

  bcd_time_of_day #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .ena(ena), .mode24(mode24),
    .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm),
    .set_ss(set_ss), .set_pm(set_pm),
`ifdef BCD_TOD_ALARM_EN
    .alarm_wr(alarm_wr), .alarm_clr(alarm_clr), .al_hh(al_hh),
    .al_mm(al_mm), .al_pm(al_pm), .alarm(alarm),
`endif
    .hh(hh), .mm(mm), .ss(ss), .pm(pm), .sec_pulse(sec_pulse),
    .day_roll(day_roll), .set_err(set_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_set(input logic [7:0] h, input logic [7:0] m,
                        input logic [7:0] s, input logic p);
    set_valid = 1'b1; set_hh = h; set_mm = m; set_ss = s; set_pm = p;
    tick();
    set_valid = 1'b0;
  endtask

  // Four qualified ena cycles from a cleared prescaler give exactly one advance
  task automatic advance();
    ena = 1'b1;
    repeat (4) tick();
    ena = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ena = 1'b0; mode24 = 1'b0; set_valid = 1'b0;
    set_hh = '0; set_mm = '0; set_ss = '0; set_pm = 1'b0;
`ifdef BCD_TOD_ALARM_EN
    alarm_wr = 1'b0; alarm_clr = 1'b0; al_hh = '0; al_mm = '0; al_pm = 1'b0;
`endif
    #12 reset = 1'b0;
    #1;
    check("rst_hh12", hh, 8'h12);
    check("rst_mm", mm, 8'h00);
    check("rst_ss", ss, 8'h00);
    check("rst_pm", {7'd0, pm}, 8'h00);
    check("rst_sp", {7'd0, sec_pulse}, 8'h00);
    check("rst_err", {7'd0, set_err}, 8'h00);
    mode24 = 1'b1;
    #1;
    check("rst_hh24", hh, 8'h00);
    check("rst_ss_hold", ss, 8'h00);

    // Prescaler: advance on every 4th qualified cycle
    ena = 1'b1;
    repeat (3) tick();
    check("div_ss_pre", ss, 8'h00);
    check("div_sp_pre", {7'd0, sec_pulse}, 8'h00);
    tick();
    check("div_ss_adv", ss, 8'h01);
    check("div_sp_adv", {7'd0, sec_pulse}, 8'h01);
    tick();
    check("div_sp_low", {7'd0, sec_pulse}, 8'h00);
    ena = 1'b0;
    tick(); tick();
    ena = 1'b1;
    tick(); tick();
    check("gap_ss_pre", ss, 8'h01);
    check("gap_sp_pre", {7'd0, sec_pulse}, 8'h00);
    tick();
    check("gap_ss_adv", ss, 8'h02);
    check("gap_sp_adv", {7'd0, sec_pulse}, 8'h01);
    ena = 1'b0;

    // 12h set 11:59:59 PM then roll the day
    mode24 = 1'b0;
    do_set(8'h11, 8'h59, 8'h59, 1'b1);
    check("set_pm_hh", hh, 8'h11);
    check("set_pm_pm", {7'd0, pm}, 8'h01);
    check("set_pm_ss", ss, 8'h59);
    check("set_no_sp", {7'd0, sec_pulse}, 8'h00);
    advance();
    check("roll_hh", hh, 8'h12);
    check("roll_mm", mm, 8'h00);
    check("roll_ss", ss, 8'h00);
    check("roll_pm", {7'd0, pm}, 8'h00);
    check("roll_dr", {7'd0, day_roll}, 8'h01);
    check("roll_sp", {7'd0, sec_pulse}, 8'h01);
    tick();
    check("roll_dr_low", {7'd0, day_roll}, 8'h00);

    // 11:59:59 AM to noon
    do_set(8'h11, 8'h59, 8'h59, 1'b0);
    advance();
    check("noon_hh", hh, 8'h12);
    check("noon_mm", mm, 8'h00);
    check("noon_pm", {7'd0, pm}, 8'h01);
    check("noon_dr", {7'd0, day_roll}, 8'h00);

    // Rejected sets leave 12:00:00 PM untouched
    mode24 = 1'b1;
    do_set(8'h24, 8'h00, 8'h00, 1'b0);
    check("err24_err", {7'd0, set_err}, 8'h01);
    check("err24_hh", hh, 8'h12);
    tick();
    check("err_low", {7'd0, set_err}, 8'h00);
    mode24 = 1'b0;
    do_set(8'h00, 8'h10, 8'h10, 1'b0);
    check("err12_err", {7'd0, set_err}, 8'h01);
    check("err12_hh", hh, 8'h12);
    check("err12_mm", mm, 8'h00);
    do_set(8'h01, 8'h5A, 8'h00, 1'b0);
    check("errmm_err", {7'd0, set_err}, 8'h01);
    check("errmm_hh", hh, 8'h12);
    check("errmm_pm", {7'd0, pm}, 8'h01);

    // Valid set coinciding with an advance wins and clears the prescaler
    ena = 1'b1;
    repeat (3) tick();
    set_valid = 1'b1; set_hh = 8'h03; set_mm = 8'h04; set_ss = 8'h05;
    set_pm = 1'b0;
    tick();
    set_valid = 1'b0; ena = 1'b0;
    check("race_hh", hh, 8'h03);
    check("race_mm", mm, 8'h04);
    check("race_ss", ss, 8'h05);
    check("race_sp", {7'd0, sec_pulse}, 8'h00);
    advance();
    check("race_next_ss", ss, 8'h06);

    // 24h set and 12h decode of an afternoon hour
    mode24 = 1'b1;
    do_set(8'h23, 8'h59, 8'h58, 1'b0);
    check("s24_hh", hh, 8'h23);
    mode24 = 1'b0;
    #1;
    check("s24_hh12", hh, 8'h11);
    check("s24_pm", {7'd0, pm}, 8'h01);

`ifdef BCD_TOD_ALARM_EN
    alarm_wr = 1'b1; al_hh = 8'h07; al_mm = 8'h30; al_pm = 1'b0;
    tick();
    alarm_wr = 1'b0;
    do_set(8'h07, 8'h29, 8'h59, 1'b0);
    check("al_idle", {7'd0, alarm}, 8'h00);
    advance();
    check("al_hit", {7'd0, alarm}, 8'h01);
    check("al_mm", mm, 8'h30);
    tick();
    check("al_low", {7'd0, alarm}, 8'h00);
    alarm_clr = 1'b1;
    tick();
    alarm_clr = 1'b0;
    do_set(8'h07, 8'h29, 8'h59, 1'b0);
    advance();
    check("al_cleared", {7'd0, alarm}, 8'h00);
    check("al_clr_mm", mm, 8'h30);
`endif

    // Asynchronous reset between edges, with a set pending
    ena = 1'b1;
    tick(); tick();
    #3;
    reset = 1'b1;
    set_valid = 1'b1; set_hh = 8'h05; set_mm = 8'h06; set_ss = 8'h07;
    #1;
    check("arst_hh", hh, 8'h12);
    check("arst_mm", mm, 8'h00);
    check("arst_ss", ss, 8'h00);
    check("arst_pm", {7'd0, pm}, 8'h00);
    tick();
    check("arst_hold_mm", mm, 8'h00);
    reset = 1'b0; set_valid = 1'b0; ena = 1'b0;
    tick();
    check("arst_post_ss", ss, 8'h00);
    check("arst_post_hh", hh, 8'h12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
